toycpu_exec_core: RTL and testbench

//  Execution core of the 16-bit toy CPU: instruction decoder, 4x16 register file and ALU with flags.

---
 rtl/toycpu_pkg.sv | 16 +
 rtl/toycpu_exec_core_if.sv | 20 ++
 rtl/toycpu_alu.sv | 32 +++
 rtl/toycpu_regfile.sv | 19 +
 rtl/toycpu_exec_core.sv | 45 ++++
 tb/tb_toycpu_exec_core.sv | 87 ++++++++
 6 files changed

// File: rtl/toycpu_pkg.sv
// toycpu_pkg: shared opcodes, ALU op indices, instruction field positions and decode helper.
package toycpu_pkg;
  localparam int DATA_W = 16;
  localparam int IMM_W  = 10;
  localparam int ALU_N  = 7;
  localparam logic [3:0] OP_NOP = 4'h0, OP_ALU = 4'h1, OP_LDI = 4'h2, OP_LD  = 4'h3,
                         OP_ST  = 4'h4, OP_LDR = 4'h5, OP_STR = 4'h6, OP_JMP = 4'h7,
                         OP_JR  = 4'h8, OP_JC  = 4'h9, OP_JZ  = 4'hA, OP_JNZ = 4'hB;
  localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_AND = 2, ALU_OR = 3, ALU_XOR = 4,
                 ALU_NOT = 5, ALU_SHL = 6;
  localparam int OP_LO = 12, RD_LO = 10, RS1_LO = 8, RS2_LO = 6, FN_LO = 0;
  localparam logic [1:0] PC_INC = 2'b00, PC_ADDR = 2'b01, PC_REG = 2'b10;
  function automatic logic [ALU_N-1:0] aluDecode(input logic [2:0] fn);
    return fn == 3'd7 ? '0 : {{ALU_N-1{1'b0}}, 1'b1} << fn;
  endfunction
endpackage

// File: rtl/toycpu_exec_core_if.sv
// toycpu_exec_core_if: processor-side bus of the execution core (instruction/data in, control/operands out).
interface toycpu_exec_core_if;
  logic [15:0] instruction;
  logic [15:0] dDataOut;
  logic [1:0]  nextPCSel;
  logic [15:0] addr;
  logic        dAddrSel;
  logic        memWE;
  logic [15:0] regOut1;
  logic [15:0] regOut2;
  logic        cFlag;
  logic        zFlag;
  logic [15:0] reg0, reg1, reg2, reg3;
  modport master (output instruction, dDataOut,
                  input nextPCSel, addr, dAddrSel, memWE, regOut1, regOut2, cFlag, zFlag,
                        reg0, reg1, reg2, reg3);
  modport slave  (input instruction, dDataOut,
                  output nextPCSel, addr, dAddrSel, memWE, regOut1, regOut2, cFlag, zFlag,
                         reg0, reg1, reg2, reg3);
endinterface

// File: rtl/toycpu_alu.sv
// toycpu_alu: one-hot ALU with registered carry/zero flags; an all-zero op holds the flags.
module toycpu_alu import toycpu_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [ALU_N-1:0]  aluOp,
  output logic [DATA_W-1:0] result,
  output logic              cFlag,
  output logic              zFlag
);
  logic [DATA_W:0] res;
  // bit DATA_W carries the carry/borrow/shifted-out bit; zero for logic ops
  always_comb begin
    res = aluOp[ALU_ADD] ? {1'b0, in1} + {1'b0, in2} :
          aluOp[ALU_SUB] ? {1'b0, in1} - {1'b0, in2} :
          aluOp[ALU_AND] ? {1'b0, in1 & in2} :
          aluOp[ALU_OR]  ? {1'b0, in1 | in2} :
          aluOp[ALU_XOR] ? {1'b0, in1 ^ in2} :
          aluOp[ALU_NOT] ? {1'b0, ~in1} :
          aluOp[ALU_SHL] ? {in1, 1'b0} : '0;
  end
  assign result = res[DATA_W-1:0];
  always_ff @(posedge clk)
    if (rst) begin
      cFlag <= 1'b0;
      zFlag <= 1'b0;
    end else if (|aluOp) begin
      cFlag <= res[DATA_W];
      zFlag <= res[DATA_W-1:0] == '0;
    end
endmodule

// File: rtl/toycpu_regfile.sv
// toycpu_regfile: 4x16 register file, two async read ports, one sync write port.
module toycpu_regfile import toycpu_pkg::*; (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [1:0]             wAddr,
  input  logic [DATA_W-1:0]      wData,
  input  logic [1:0]             rAddr1,
  input  logic [1:0]             rAddr2,
  output logic [DATA_W-1:0]      rData1,
  output logic [DATA_W-1:0]      rData2,
  output logic [3:0][DATA_W-1:0] regs
);
  always_ff @(posedge clk)
    if (rst) regs <= '0;
    else if (we) regs[wAddr] <= wData;
  assign rData1 = regs[rAddr1];
  assign rData2 = regs[rAddr2];
endmodule

// File: rtl/toycpu_exec_core.sv
// toycpu_exec_core: inline decoder plus register file and ALU of the 16-bit toy CPU.
module toycpu_exec_core import toycpu_pkg::*; (
  input logic clk,
  input logic rst,
  toycpu_exec_core_if.slave bus
);
  logic [3:0]             op;
  logic [1:0]             rd, rs1, rs2;
  logic [ALU_N-1:0]       aluOp;
  logic                   regWE, cFlag, zFlag;
  logic [DATA_W-1:0]      addr, wData, aluRes, rData1, rData2;
  logic [3:0][DATA_W-1:0] regs;
  assign op   = bus.instruction[OP_LO+:4];
  assign rd   = bus.instruction[RD_LO+:2];
  assign rs1  = bus.instruction[RS1_LO+:2];
  assign addr = {{DATA_W-IMM_W{1'b0}}, bus.instruction[IMM_W-1:0]};
  // stores take their data register from the rd slot
  always_comb begin
    rs2           = (op == OP_ST || op == OP_STR) ? bus.instruction[RD_LO+:2] : bus.instruction[RS2_LO+:2];
    aluOp         = op == OP_ALU ? aluDecode(bus.instruction[FN_LO+:3]) : '0;
    regWE         = |aluOp || op == OP_LDI || op == OP_LD || op == OP_LDR;
    wData         = op == OP_LDI ? addr : (op == OP_LD || op == OP_LDR) ? bus.dDataOut : aluRes;
    bus.nextPCSel = (op == OP_JMP || (op == OP_JC && cFlag) || (op == OP_JZ && zFlag) ||
                     (op == OP_JNZ && !zFlag)) ? PC_ADDR : op == OP_JR ? PC_REG : PC_INC;
    bus.dAddrSel  = op == OP_LDR || op == OP_STR;
    bus.memWE     = op == OP_ST || op == OP_STR;
  end
  toycpu_regfile u_regfile (
    .clk(clk), .rst(rst), .we(regWE), .wAddr(rd), .wData(wData),
    .rAddr1(rs1), .rAddr2(rs2), .rData1(rData1), .rData2(rData2), .regs(regs)
  );
  toycpu_alu u_alu (
    .clk(clk), .rst(rst), .in1(rData1), .in2(rData2), .aluOp(aluOp),
    .result(aluRes), .cFlag(cFlag), .zFlag(zFlag)
  );
  assign bus.addr    = addr;
  assign bus.regOut1 = rData1;
  assign bus.regOut2 = rData2;
  assign bus.cFlag   = cFlag;
  assign bus.zFlag   = zFlag;
  assign bus.reg0    = regs[0];
  assign bus.reg1    = regs[1];
  assign bus.reg2    = regs[2];
  assign bus.reg3    = regs[3];
endmodule

// File: tb/tb_toycpu_exec_core.sv
// tb_toycpu_exec_core: directed instruction stream with a queue scoreboard checked at each falling edge.
module tb_toycpu_exec_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nChecks = 0;
  int nFails = 0;
  toycpu_exec_core_if bus();
  toycpu_exec_core dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // packed order: nextPCSel, addr, dAddrSel, memWE, regOut1, regOut2, cFlag, zFlag, reg0..reg3
  typedef struct {
    string        name;
    logic [117:0] v;
  } exp_t;
  exp_t sb[$];
  task automatic step(input string nm, input logic [15:0] ins, input logic [15:0] dd,
                      input logic [1:0] sel, input logic [15:0] ad, input logic das, input logic we,
                      input logic [15:0] o1, input logic [15:0] o2, input logic c, input logic z,
                      input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                      input logic [15:0] e3);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.instruction = ins;
    bus.dDataOut = dd;
    e.name = nm;
    e.v = {sel, ad, das, we, o1, o2, c, z, e0, e1, e2, e3};
    sb.push_back(e);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [117:0] act;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      act = {bus.nextPCSel, bus.addr, bus.dAddrSel, bus.memWE, bus.regOut1, bus.regOut2,
             bus.cFlag, bus.zFlag, bus.reg0, bus.reg1, bus.reg2, bus.reg3};
      nChecks++;
      if (act !== e.v) begin
        nFails++;
        $display("FAIL %s: got %h expected %h (sel,addr,das,we,o1,o2,c,z,r0..r3)", e.name, act, e.v);
      end
    end
  end
  initial begin
    bus.instruction = 16'h27FF;
    bus.dDataOut = 16'h0;
    repeat (2) @(posedge clk);
    //   name           instr     dData     sel  addr     das   we    regOut1   regOut2   C     Z     r0        r1        r2        r3
    step("rst_ldi_r1",  16'h27FF, 16'h0000, 2'd0, 16'h3FF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    step("ldi_r2",      16'h2801, 16'h0000, 2'd0, 16'h001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h03FF, 16'h0000, 16'h0000);
    step("add_r3",      16'h1D80, 16'h0000, 2'd0, 16'h180, 1'b0, 1'b0, 16'h03FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h03FF, 16'h0001, 16'h0000);
    step("ldi_r0",      16'h2000, 16'h0000, 2'd0, 16'h000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h03FF, 16'h0001, 16'h0400);
    step("sub_borrow",  16'h1481, 16'h0000, 2'd0, 16'h081, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h03FF, 16'h0001, 16'h0400);
    step("add_wrap",    16'h1D80, 16'h0000, 2'd0, 16'h180, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0001, 16'h0400);
    step("jz_taken",    16'hA020, 16'h0000, 2'd1, 16'h020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000);
    step("jnz_not",     16'hB020, 16'h0000, 2'd0, 16'h020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000);
    step("jc_taken",    16'h9030, 16'h0000, 2'd1, 16'h030, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000);
    step("st_r2",       16'h4810, 16'h0000, 2'd0, 16'h010, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000);
    step("ldi_r1_5",    16'h2405, 16'h0000, 2'd0, 16'h005, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000);
    step("jr_r1",       16'h8100, 16'h0000, 2'd2, 16'h100, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0005, 16'h0001, 16'h0000);
    step("ldr_r3",      16'h5D00, 16'hBEEF, 2'd0, 16'h100, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0005, 16'h0001, 16'h0000);
    step("str_r3",      16'h6D00, 16'h0000, 2'd0, 16'h100, 1'b1, 1'b1, 16'h0005, 16'hBEEF, 1'b1, 1'b1, 16'h0000, 16'h0005, 16'h0001, 16'hBEEF);
    step("ld_r0",       16'h303A, 16'h1234, 2'd0, 16'h03A, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0005, 16'h0001, 16'hBEEF);
    step("same_cyc_rw", 16'h2555, 16'h0000, 2'd0, 16'h155, 1'b0, 1'b0, 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h1234, 16'h0005, 16'h0001, 16'hBEEF);
    step("alu_fn7",     16'h1547, 16'h0000, 2'd0, 16'h147, 1'b0, 1'b0, 16'h0155, 16'h0155, 1'b1, 1'b1, 16'h1234, 16'h0155, 16'h0001, 16'hBEEF);
    step("fn7_hold",    16'h0000, 16'h0000, 2'd0, 16'h000, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b1, 1'b1, 16'h1234, 16'h0155, 16'h0001, 16'hBEEF);
    step("xor_r2",      16'h1944, 16'h0000, 2'd0, 16'h144, 1'b0, 1'b0, 16'h0155, 16'h0155, 1'b1, 1'b1, 16'h1234, 16'h0155, 16'h0001, 16'hBEEF);
    step("shl_r3",      16'h1C06, 16'h0000, 2'd0, 16'h006, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h1234, 16'h0155, 16'h0000, 16'hBEEF);
    step("not_r1",      16'h1605, 16'h0000, 2'd0, 16'h205, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0, 16'h1234, 16'h0155, 16'h0000, 16'h2468);
    step("jc_not",      16'h9030, 16'h0000, 2'd0, 16'h030, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0, 16'h1234, 16'hFFFF, 16'h0000, 16'h2468);
    step("jmp",         16'h73FF, 16'h0000, 2'd1, 16'h3FF, 1'b0, 1'b0, 16'h2468, 16'h2468, 1'b0, 1'b0, 16'h1234, 16'hFFFF, 16'h0000, 16'h2468);
    step("op_c_nop",    16'hC0FF, 16'h0000, 2'd0, 16'h0FF, 1'b0, 1'b0, 16'h1234, 16'h2468, 1'b0, 1'b0, 16'h1234, 16'hFFFF, 16'h0000, 16'h2468);
    step("jnz_taken",   16'hB020, 16'h0000, 2'd1, 16'h020, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0, 16'h1234, 16'hFFFF, 16'h0000, 16'h2468);
    step("shl_carry",   16'h1906, 16'h0000, 2'd0, 16'h106, 1'b0, 1'b0, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 16'h1234, 16'hFFFF, 16'h0000, 16'h2468);
    step("shl_result",  16'h0000, 16'h0000, 2'd0, 16'h000, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b1, 1'b0, 16'h1234, 16'hFFFF, 16'hFFFE, 16'h2468);
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      nChecks++;
      nFails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
